// File: rtl/rv32_mc_pkg.sv
// rtl/rv32_mc_pkg.sv - shared encodings for the multi-cycle RV32 control FSM
package rv32_mc_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam int MEM_TIMEOUT_MIN = 1;
  localparam int MEM_TIMEOUT_MAX = 255;
  localparam int WAIT_CNT_W      = 8;

  // LW/SW only in word form; branches only BEQ/BNE.
  function automatic logic is_supported(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R, OP_I, OP_JAL: ok = 1'b1;
      OP_LW, OP_SW:       ok = (f3 == 3'b010);
      OP_BR:              ok = (f3[2:1] == 2'b00);
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts consecutive unanswered memory request cycles
module mem_wait_timer
  import rv32_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || ready_i) begin
      cnt_d = '0;
    end else if (cnt_q != {WAIT_CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the MEM_TIMEOUT-th waiting cycle; a same-cycle ready wins.
  assign timeout_o = req_i && !ready_i && (cnt_q == LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB control FSM for the multi-cycle RV32 core
module multicycle_ctrl
  import rv32_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  aluop,
  output logic [3:0]  funct,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] instret
);

  logic [2:0]  state_q, state_d;
  logic        illegal_q, bus_err_q;
  logic [31:0] instret_q;

  logic mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c;
  logic retire, set_illegal, timeout;

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    reg_we_c     = 1'b0;
    mem_addr_sel = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    aluop        = ALUOP_ADD;
    funct        = 4'b0000;
    wb_sel       = WB_ALUOUT;
    retire       = 1'b0;
    set_illegal  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (is_supported(opcode, funct3)) begin
          state_d = ST_EXEC;
        end else begin
          state_d     = ST_TRAP;
          set_illegal = 1'b1;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_src_a = SRCA_RS1;
            aluop     = ALUOP_FUNCT;
            funct     = {funct7_5, funct3};
            state_d   = ST_WB;
          end
          OP_I: begin
            // Only SRAI/SRLI use IR[30]; elsewhere it is immediate data.
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            aluop     = ALUOP_FUNCT;
            funct     = {(funct3 == 3'b101) && funct7_5, funct3};
            state_d   = ST_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = ST_MEM;
          end
          OP_BR: begin
            alu_src_a = SRCA_RS1;
            aluop     = ALUOP_SUB;
            pc_src    = 1'b1;
            pc_we_c   = zero ^ funct3[0];
            retire    = 1'b1;
            state_d   = ST_FETCH;
          end
          OP_JAL: begin
            pc_src   = 1'b1;
            pc_we_c  = 1'b1;
            reg_we_c = 1'b1;
            wb_sel   = WB_PC;
            retire   = 1'b1;
            state_d  = ST_FETCH;
          end
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        mem_req_c    = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we_c     = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_we_c = 1'b1;
        wb_sel   = (opcode == OP_LW) ? WB_MDR : WB_ALUOUT;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_TRAP;
    endcase

    if (timeout) begin
      state_d = ST_TRAP;
    end
  end

  // Strobes are gated by reset so nothing leaks during a mid-instruction reset.
  assign mem_req = mem_req_c & rst_n;
  assign mem_we  = mem_we_c  & rst_n;
  assign ir_we   = ir_we_c   & rst_n;
  assign pc_we   = pc_we_c   & rst_n;
  assign reg_we  = reg_we_c  & rst_n;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (mem_req),
    .ready_i  (mem_ready),
    .timeout_o(timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal_q <= 1'b1;
      if (timeout)     bus_err_q <= 1'b1;
      if (retire)      instret_q <= instret_q + 32'd1;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we;
  logic [1:0]  alu_src_a, alu_src_b, aluop, wb_sel;
  logic [3:0]  funct;
  logic [2:0]  state;
  logic        illegal, bus_err;
  logic [31:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .funct(funct),
    .reg_we(reg_we), .wb_sel(wb_sel), .state(state), .illegal(illegal),
    .bus_err(bus_err), .instret(instret)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    opcode   = op;
    funct3   = f3;
    funct7_5 = f75;
  endtask

  // Leaves the bench mid-cycle in EXEC of the given instruction.
  task automatic run_to_exec(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f75);
    set_ir(op, f3, f75);
    mem_ready = 1'b1;
    #1;
    check({name, "_fetch_state"}, state, 0);
    tick();
    #1;
    check({name, "_decode_state"}, state, 1);
    tick();
    #1;
    check({name, "_exec_state"}, state, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b0;
    set_ir(7'b0110011, 3'b000, 1'b1);
    tick();
    #1;
    check("rst_state", state, 0);
    check("rst_instret", instret, 0);
    check("rst_illegal", illegal, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_mem_req_forced", mem_req, 0);
    check("rst_ir_we_forced", ir_we, 0);
    rst_n = 1'b1;

    // SUB via R-type: 0,1,2,4,0
    #1;
    check("add_fetch_req", mem_req, 1);
    check("add_fetch_ir_we", ir_we, 1);
    check("add_fetch_pc_we", pc_we, 1);
    check("add_fetch_srcb", alu_src_b, 1);
    tick(); #1;
    check("add_decode_state", state, 1);
    check("add_decode_srca", alu_src_a, 1);
    check("add_decode_srcb", alu_src_b, 2);
    check("add_decode_reg_we", reg_we, 0);
    tick(); #1;
    check("add_exec_state", state, 2);
    check("add_exec_aluop", aluop, 2);
    check("add_exec_funct", funct, 4'b1000);
    check("add_exec_reg_we", reg_we, 0);
    tick(); #1;
    check("add_wb_state", state, 4);
    check("add_wb_reg_we", reg_we, 1);
    check("add_wb_sel", wb_sel, 0);
    check("add_wb_instret", instret, 0);
    tick(); #1;
    check("add_done_state", state, 0);
    check("add_done_instret", instret, 1);

    // LW with three wait cycles in MEM
    run_to_exec("lw", 7'b0000011, 3'b010, 1'b0);
    check("lw_exec_aluop", aluop, 0);
    check("lw_exec_srca", alu_src_a, 2);
    check("lw_exec_srcb", alu_src_b, 2);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lw_mem_wait_state", state, 3);
      check("lw_mem_wait_req", mem_req, 1);
      check("lw_mem_wait_we", mem_we, 0);
      check("lw_mem_wait_addr_sel", mem_addr_sel, 1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("lw_mem_last_state", state, 3);
    check("lw_mem_last_req", mem_req, 1);
    check("lw_mem_last_ir_we", ir_we, 0);
    tick(); #1;
    check("lw_wb_state", state, 4);
    check("lw_wb_sel", wb_sel, 1);
    check("lw_wb_reg_we", reg_we, 1);
    tick(); #1;
    check("lw_done_state", state, 0);
    check("lw_done_instret", instret, 2);

    // BEQ taken, BNE not taken
    zero = 1'b1;
    run_to_exec("beq", 7'b1100011, 3'b000, 1'b0);
    check("beq_pc_we", pc_we, 1);
    check("beq_pc_src", pc_src, 1);
    check("beq_aluop", aluop, 1);
    tick(); #1;
    check("beq_done_state", state, 0);
    check("beq_done_instret", instret, 3);
    run_to_exec("bne", 7'b1100011, 3'b001, 1'b0);
    check("bne_pc_we", pc_we, 0);
    check("bne_pc_src", pc_src, 1);
    tick(); #1;
    check("bne_done_state", state, 0);
    check("bne_done_instret", instret, 4);

    // JAL
    run_to_exec("jal", 7'b1101111, 3'b000, 1'b0);
    check("jal_pc_we", pc_we, 1);
    check("jal_reg_we", reg_we, 1);
    check("jal_wb_sel", wb_sel, 2);
    tick(); #1;
    check("jal_done_instret", instret, 5);

    // I-type: IR[30] only matters for shift-right
    run_to_exec("srai", 7'b0010011, 3'b101, 1'b1);
    check("srai_funct", funct, 4'b1101);
    check("srai_aluop", aluop, 2);
    tick(); #1;
    check("srai_wb_state", state, 4);
    tick(); #1;
    run_to_exec("addi", 7'b0010011, 3'b000, 1'b1);
    check("addi_funct", funct, 4'b0000);
    tick(); tick(); #1;
    check("addi_done_instret", instret, 7);

    // Illegal opcode -> TRAP, sticky, cleared by reset
    set_ir(7'b1110011, 3'b000, 1'b0);
    mem_ready = 1'b1;
    tick(); #1;
    check("ill_decode_state", state, 1);
    tick(); #1;
    check("ill_trap_state", state, 5);
    check("ill_flag", illegal, 1);
    tick(); #1;
    check("ill_trap_hold", state, 5);
    check("ill_flag_sticky", illegal, 1);
    check("ill_trap_req", mem_req, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("ill_rst_state", state, 0);
    check("ill_rst_flag", illegal, 0);
    check("ill_rst_instret", instret, 0);

    // FETCH timeout: 15 unanswered cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    #1;
    check("to_cycle15_state", state, 0);
    check("to_cycle15_bus_err", bus_err, 0);
    check("to_cycle15_req", mem_req, 1);
    tick(); #1;
    check("to_trap_state", state, 5);
    check("to_bus_err", bus_err, 1);
    tick(); #1;
    check("to_bus_err_sticky", bus_err, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    mem_ready = 1'b1;
    #1;
    check("to_ready_ir_we", ir_we, 1);
    tick(); #1;
    check("to_ready_state", state, 1);
    check("to_ready_bus_err", bus_err, 0);

    // Reset during MEM of an SW
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_to_exec("sw", 7'b0100011, 3'b010, 1'b0);
    tick();
    mem_ready = 1'b0;
    #1;
    check("sw_mem_state", state, 3);
    check("sw_mem_we", mem_we, 1);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("sw_rst_mem_we", mem_we, 0);
    check("sw_rst_pc_we", pc_we, 0);
    check("sw_rst_mem_req", mem_req, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("sw_rst_state", state, 0);
    check("sw_rst_instret", instret, 0);
    check("sw_rst_fetch_req", mem_req, 1);
    run_to_exec("sw2", 7'b0100011, 3'b010, 1'b0);
    tick(); #1;
    check("sw2_mem_we", mem_we, 1);
    tick(); #1;
    check("sw2_done_state", state, 0);
    check("sw2_done_instret", instret, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle RV32 core variant: one shared ALU, one shared memory port, instructions stepped through FETCH/DECODE/EXEC/MEM/WB.
- Per state, drives datapath strobes, mux selects, and the {aluop, funct} pair consumed by the ALU control decoder.
- Owns the memory req/ready handshake, a memory-wait timeout, and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 15, max consecutive cycles mem_req may stay high without mem_ready before bus_err (range 1..255)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous, active-low reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
zero  in  1  ALU zero flag, valid in EXEC
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write request (SW)
mem_addr_sel  out  1  0=PC, 1=ALUOut
ir_we  out  1  load IR (and MDR) from mem rdata
pc_we  out  1  PC write enable
pc_src  out  1  0=ALU result, 1=ALUOut
alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1
alu_src_b  out  2  00=rs2, 01=const 4, 10=imm
aluop  out  2  00=add, 01=sub, 10=use funct
funct  out  4  {funct7_5_eff, funct3} to ALU control
reg_we  out  1  register-file write
wb_sel  out  2  00=ALUOut, 01=MDR, 10=PC (already +4)
state  out  3  current state, debug
illegal  out  1  sticky, unsupported opcode seen
bus_err  out  1  sticky, memory timeout
instret  out  32  retired instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Registered state; outputs are combinational from state + inputs. Any unused encoding goes to TRAP.
- Reset (rst_n low at posedge): state=FETCH, instret=0, illegal=0, bus_err=0, wait counter=0. While rst_n is low, all strobes (mem_req, mem_we, ir_we, pc_we, reg_we) are forced to 0.
- Defaults every state: strobes 0, selects 0, aluop=00.
- FETCH:
  - mem_req=1, mem_addr_sel=0, alu_src_a=00, alu_src_b=01, aluop=00, pc_src=0.
  - On mem_ready: ir_we=1, pc_we=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - alu_src_a=01, alu_src_b=10, aluop=00 (branch/jump target into ALUOut).
  - Supported opcodes: R 0110011, I 0010011, LW 0000011 with funct3=010, SW 0100011 with funct3=010, BRANCH 1100011 with funct3 in {000,001}, JAL 1101111.
  - Supported -> EXEC. Anything else -> TRAP, illegal set.
- EXEC:
  - R: src_a=10, src_b=00, aluop=10, funct={funct7_5,funct3} -> WB.
  - I: src_a=10, src_b=10, aluop=10. funct7_5_eff = funct7_5 only when funct3=101, else 0 -> WB.
  - LW/SW: src_a=10, src_b=10, aluop=00 -> MEM.
  - BRANCH: src_a=10, src_b=00, aluop=01, pc_src=1, pc_we=(zero XOR funct3[0]); retire; -> FETCH.
  - JAL: pc_src=1, pc_we=1, reg_we=1, wb_sel=10; retire; -> FETCH.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=(SW).
  - On mem_ready: SW retires and goes to FETCH. LW asserts ir_we-equivalent MDR capture (ir_we stays 0; MDR is always loaded) and goes to WB.
- WB: reg_we=1, wb_sel=01 for LW, else 00; retire; -> FETCH.
- TRAP: all strobes 0; absorbing until reset.
- instret increments by 1 on each retire cycle and wraps 0xFFFFFFFF -> 0.
- Wait counter:
  - Increments each cycle mem_req=1 and mem_ready=0; clears on mem_ready or on leaving FETCH/MEM.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: bus_err=1 next cycle, state -> TRAP.
  - mem_ready in the same cycle as the timeout wins: the transfer completes and there is no error.
- mem_ready while mem_req=0 is ignored.
- Latency with zero-wait memory: R/I 4 cycles, LW 5, SW 4, BRANCH 3, JAL 3.
- Reset mid-instruction: the next cycle is FETCH with no strobe leakage.

Decomposition:
- Package rv32_mc_pkg holds: state encoding, opcode constants, aluop/alu_src/wb_sel encodings, MEM_TIMEOUT bounds.
- Sub-module mem_wait_timer (counter + timeout compare, parameter MEM_TIMEOUT).

Test Plan:
- ADD (opcode 0110011, funct7_5=1, funct3=000 -> SUB), mem_ready tied 1:
  - Expected state sequence 0,1,2,4,0.
  - EXEC shows aluop=10, funct=1000.
  - reg_we=1 in WB only; instret 0->1.
- LW with mem_ready delayed 3 cycles in MEM:
  - mem_req/mem_we=1/0 held 4 cycles in MEM.
  - Then WB with wb_sel=01; total 8 cycles.
- BEQ with zero=1 -> pc_we=1, pc_src=1 in EXEC. BNE with zero=1 -> pc_we=0. Both return to FETCH after 3 cycles.
- Opcode 1110011 -> DECODE then TRAP, illegal=1 sticky; rst_n low 1 cycle -> FETCH, illegal=0.
- FETCH with mem_ready never asserted, MEM_TIMEOUT=15:
  - bus_err=1 after 15 wait cycles, state=5.
  - Repeat with mem_ready on the 15th cycle -> no error, DECODE.
- Assert rst_n=0 during MEM of an SW: no mem_we/pc_we during reset, instret unchanged; restart in FETCH.
